// File: rtl/music_pkg.sv
// Shared definitions for the music sequencer: FSM state encoding and
// default codes/timing used by the top and its tick timer.
package music_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        PLAY  = 2'd3
    } state_t;

    localparam int         DEF_ADDR_W    = 8;
    localparam int         DEF_NOTE_W    = 8;
    localparam int         DEF_TICK_DIV  = 2**21;
    localparam logic [7:0] DEF_END_CODE  = 8'hFF;
    localparam logic [7:0] DEF_REST_CODE = 8'h00;

endpackage

// File: rtl/music_sequencer_if.sv
// Game-logic / ROM / tone-generator side signals of the music sequencer.
interface music_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int NOTE_W = 8
) ();

    logic              song_start;
    logic              song_stop;
    logic              song_loop;
    logic              pause;
    logic              sfx_req;
    logic [ADDR_W-1:0] sfx_base;
    logic              sfx_ack;
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] rom_data;
    logic [NOTE_W-1:0] note;
    logic              busy;
    logic              sfx_active;
    logic              song_done;

    // Game logic plus ROM: drives the controls and read data
    modport master (
        output song_start, song_stop, song_loop, pause, sfx_req, sfx_base, rom_data,
        input  sfx_ack, rom_addr, note, busy, sfx_active, song_done
    );

    // Sequencer side
    modport slave (
        input  song_start, song_stop, song_loop, pause, sfx_req, sfx_base, rom_data,
        output sfx_ack, rom_addr, note, busy, sfx_active, song_done
    );

endinterface

// File: rtl/music_tick_timer.sv
// Per-note duration counter: counts enabled cycles 0..TICK_DIV-1 and flags
// the last one. Clear has priority over enable.
module music_tick_timer #(
    parameter int TICK_DIV = music_pkg::DEF_TICK_DIV
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic done_o
);

    localparam int            TW   = $clog2(TICK_DIV);
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;

    // Next count: hold, clear, or advance with wrap at the last tick
    always_comb begin
        tick_d = tick_q;
        if (clear_i) begin
            tick_d = '0;
        end else if (enable_i) begin
            tick_d = (tick_q == LAST) ? '0 : tick_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign done_o = (tick_q == LAST);

endmodule

// File: rtl/music_sequencer.sv
// Note-ROM sequencer: plays a background song with start/stop/loop/pause and
// lets sound effects preempt it, resuming the song at the interrupted note.
module music_sequencer
    import music_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                NOTE_W    = DEF_NOTE_W,
    parameter int                TICK_DIV  = DEF_TICK_DIV,
    parameter logic [NOTE_W-1:0] END_CODE  = NOTE_W'(DEF_END_CODE),
    parameter logic [NOTE_W-1:0] REST_CODE = NOTE_W'(DEF_REST_CODE)
) (
    input  logic               clock,
    input  logic               reset_n,
    music_sequencer_if.slave   bus
);

    state_t            state_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] saved_q;
    logic [NOTE_W-1:0] note_q;
    logic              song_on_q;
    logic              sfx_active_q;
    logic              sfx_ack_q;
    logic              song_done_q;
    logic              tick_done;

    // The timer only runs in PLAY; leaving PLAY re-arms it for the next note
    music_tick_timer #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear_i  (state_q != PLAY),
        .enable_i ((state_q == PLAY) && !bus.pause),
        .done_o   (tick_done)
    );

    // Sequencer FSM with song context save; stop > sfx > start > internal events
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rom_addr_q   <= '0;
            saved_q      <= '0;
            note_q       <= REST_CODE;
            song_on_q    <= 1'b0;
            sfx_active_q <= 1'b0;
            sfx_ack_q    <= 1'b0;
            song_done_q  <= 1'b0;
        end else begin
            sfx_ack_q   <= 1'b0;
            song_done_q <= 1'b0;
            if (bus.song_stop) begin
                state_q      <= IDLE;
                sfx_active_q <= 1'b0;
                song_on_q    <= 1'b0;
                note_q       <= REST_CODE;
            end else if (bus.sfx_req) begin
                // Only the first sfx of a burst saves the song position
                if (!sfx_active_q && state_q != IDLE) begin
                    saved_q <= rom_addr_q;
                end
                rom_addr_q   <= bus.sfx_base;
                sfx_active_q <= 1'b1;
                sfx_ack_q    <= 1'b1;
                state_q      <= FETCH;
            end else if (bus.song_start) begin
                song_on_q <= 1'b1;
                if (sfx_active_q) begin
                    saved_q <= '0;
                end else begin
                    rom_addr_q <= '0;
                    state_q    <= FETCH;
                end
            end else begin
                case (state_q)
                    IDLE:  state_q <= IDLE;
                    FETCH: state_q <= WAIT;
                    WAIT: begin
                        if (bus.rom_data == END_CODE) begin
                            if (sfx_active_q) begin
                                sfx_active_q <= 1'b0;
                                if (song_on_q) begin
                                    rom_addr_q <= saved_q;
                                    state_q    <= FETCH;
                                end else begin
                                    note_q  <= REST_CODE;
                                    state_q <= IDLE;
                                end
                            end else if (bus.song_loop) begin
                                rom_addr_q <= '0;
                                state_q    <= FETCH;
                            end else begin
                                song_done_q <= 1'b1;
                                song_on_q   <= 1'b0;
                                note_q      <= REST_CODE;
                                state_q     <= IDLE;
                            end
                        end else begin
                            note_q  <= bus.rom_data;
                            state_q <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (tick_done && !bus.pause) begin
                            rom_addr_q <= rom_addr_q + 1'b1;
                            state_q    <= FETCH;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Pause silences the output without disturbing the held note
    assign bus.note       = bus.pause ? REST_CODE : note_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.sfx_active = sfx_active_q;
    assign bus.sfx_ack    = sfx_ack_q;
    assign bus.song_done  = song_done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer with TICK_DIV=4 and a 1-cycle synchronous ROM.
module tb_music_sequencer;

    localparam int TICK_DIV = 4;
    localparam int C        = 100;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    music_sequencer_if #(.ADDR_W(8), .NOTE_W(8)) bus ();

    music_sequencer #(
        .ADDR_W(8), .NOTE_W(8), .TICK_DIV(TICK_DIV),
        .END_CODE(8'hFF), .REST_CODE(8'h00)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [7:0] rom [256];
    always @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // move to the drive point of the next cycle
    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.song_start = 0; bus.song_stop = 0; bus.song_loop = 0;
        bus.pause = 0; bus.sfx_req = 0; bus.sfx_base = 8'h00;
    endtask

    task automatic go_idle();
        clear_inputs();
        bus.song_stop = 1;
        nxt();
        bus.song_stop = 0;
        nxt();
    endtask

    task automatic load_basic();
        for (int i = 0; i < 256; i++) rom[i] = 8'h11;
        rom[0] = 8'h05; rom[1] = 8'h07; rom[2] = 8'hFF;
        rom[8'h10] = 8'h20; rom[8'h11] = 8'hFF;
    endtask

    typedef struct {
        logic       st, sp, sr;
        logic [7:0] base;
        logic [7:0] note;
        logic [3:0] flags;   // busy, sfx_active, sfx_ack, song_done
        logic [7:0] addr;
    } vec_t;

    function automatic vec_t v(input logic st, input logic sp, input logic sr, input logic [7:0] base,
                               input logic [7:0] note, input logic [3:0] flags, input logic [7:0] addr);
        vec_t r;
        r.st = st; r.sp = sp; r.sr = sr; r.base = base;
        r.note = note; r.flags = flags; r.addr = addr;
        return r;
    endfunction

    function automatic logic [31:0] outs();
        return {12'h0, bus.note, bus.busy, bus.sfx_active, bus.sfx_ack, bus.song_done, bus.rom_addr};
    endfunction

    // reference model arrays for one random song run
    logic       pause_arr [C];
    logic [7:0] exp_note  [C];
    logic       exp_busy  [C];
    logic       exp_done  [C];

    // Build the expected per-cycle view from the song's entries: every entry
    // costs a fetch and a read cycle, then TICK_DIV un-paused cycles of play.
    task automatic build_model(input int len, input logic loop_en);
        logic [7:0] held;
        int t, idx, cnt;
        held = 8'h00; t = 0; idx = 0;
        for (int i = 0; i < C; i++) begin
            exp_note[i] = 8'h00; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
        end
        while (t < C) begin
            for (int k = 0; k < 2 && t < C; k++) begin
                exp_note[t] = held; exp_busy[t] = 1'b1; t++;
            end
            if (t >= C) break;
            if (idx == len) begin
                if (loop_en) begin
                    idx = 0;
                    continue;
                end
                exp_done[t] = 1'b1;
                break;
            end
            held = rom[idx];
            cnt  = 0;
            while (cnt < TICK_DIV && t < C) begin
                exp_note[t] = held; exp_busy[t] = 1'b1;
                if (!pause_arr[t]) cnt++;
                t++;
            end
            idx++;
        end
        for (int i = 0; i < C; i++) if (pause_arr[i]) exp_note[i] = 8'h00;
    endtask

    initial begin
        vec_t       tbl [$];
        logic [7:0] nq [$];
        logic [7:0] last_note, prev_addr;
        logic       found, wrap_ok, saw_done;
        int         len;
        logic       loop_en;

        clear_inputs();
        load_basic();
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", outs(), 32'h0);
        reset_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        tbl.push_back(v(1,0,0,8'h00, 8'h00,4'b0000,8'h00));
        tbl.push_back(v(0,0,0,8'h00, 8'h00,4'b1000,8'h00));
        tbl.push_back(v(0,0,0,8'h00, 8'h00,4'b1000,8'h00));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0,0,0,8'h00, 8'h05,4'b1000,8'h00));
        for (int i = 0; i < 2; i++) tbl.push_back(v(0,0,0,8'h00, 8'h05,4'b1000,8'h01));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0,0,0,8'h00, 8'h07,4'b1000,8'h01));
        for (int i = 0; i < 2; i++) tbl.push_back(v(0,0,0,8'h00, 8'h07,4'b1000,8'h02));
        tbl.push_back(v(0,0,0,8'h00, 8'h00,4'b0001,8'h02));
        tbl.push_back(v(0,1,1,8'h10, 8'h00,4'b0000,8'h02));
        tbl.push_back(v(1,1,0,8'h00, 8'h00,4'b0000,8'h02));
        tbl.push_back(v(1,0,0,8'h00, 8'h00,4'b0000,8'h02));
        tbl.push_back(v(0,0,0,8'h00, 8'h00,4'b1000,8'h00));
        tbl.push_back(v(0,0,0,8'h00, 8'h00,4'b1000,8'h00));
        tbl.push_back(v(0,1,1,8'h10, 8'h05,4'b1000,8'h00));
        tbl.push_back(v(0,0,0,8'h00, 8'h00,4'b0000,8'h00));
        tbl.push_back(v(1,0,0,8'h00, 8'h00,4'b0000,8'h00));
        tbl.push_back(v(0,0,0,8'h00, 8'h00,4'b1000,8'h00));
        tbl.push_back(v(1,1,0,8'h00, 8'h00,4'b1000,8'h00));
        tbl.push_back(v(0,0,0,8'h00, 8'h00,4'b0000,8'h00));
        tbl.push_back(v(0,0,0,8'h00, 8'h00,4'b0000,8'h00));
        for (int i = 0; i < tbl.size(); i++) begin
            bus.song_start = tbl[i].st; bus.song_stop = tbl[i].sp;
            bus.sfx_req = tbl[i].sr; bus.sfx_base = tbl[i].base;
            @(negedge clock);
            check($sformatf("tbl_row%0d", i), outs(),
                  {12'h0, tbl[i].note, tbl[i].flags, tbl[i].addr});
            nxt();
        end
        clear_inputs();
        nxt();

        // ---------------- looping song ----------------
        go_idle();
        bus.song_loop = 1; bus.song_start = 1;
        nxt();
        bus.song_start = 0;
        last_note = 8'h00; prev_addr = 8'h00; wrap_ok = 0; saw_done = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clock);
            if (bus.note != last_note) begin nq.push_back(bus.note); last_note = bus.note; end
            if (bus.song_done) saw_done = 1;
            if (prev_addr == 8'h02 && bus.rom_addr == 8'h00) wrap_ok = 1;
            prev_addr = bus.rom_addr;
            nxt();
        end
        check("loop_done_never", {31'h0, saw_done}, 32'h0);
        check("loop_addr_to_0", {31'h0, wrap_ok}, 32'h1);
        check("loop_n_changes", nq.size() >= 4 ? 32'd4 : nq.size(), 32'd4);
        for (int i = 0; i < 4 && i < nq.size(); i++)
            check($sformatf("loop_note%0d", i), {24'h0, nq[i]}, (i % 2 == 0) ? 32'h05 : 32'h07);

        // ---------------- sfx preemption ----------------
        go_idle();
        bus.song_start = 1;
        nxt();
        bus.song_start = 0;
        found = 0;
        for (int t = 0; t < 30 && !found; t++) begin
            @(negedge clock);
            if (bus.note == 8'h07) found = 1;
            nxt();
        end
        check("sfx_wait_note07", {31'h0, found}, 32'h1);
        bus.sfx_req = 1; bus.sfx_base = 8'h10;
        nxt();
        bus.sfx_req = 0; bus.sfx_base = 8'h00;
        @(negedge clock);
        check("sfx_ack_pulse", {bus.sfx_ack, bus.sfx_active, bus.rom_addr}, {2'b11, 8'h10});
        nxt(); @(negedge clock);
        check("sfx_ack_single", {31'h0, bus.sfx_ack}, 32'h0);
        nxt(); @(negedge clock);
        check("sfx_note", {bus.sfx_active, bus.note}, {1'b1, 8'h20});
        repeat (6) begin nxt(); @(negedge clock); end
        check("sfx_resume_addr", {bus.sfx_active, bus.rom_addr}, {1'b0, 8'h01});
        repeat (2) begin nxt(); @(negedge clock); end
        check("sfx_resume_note", {24'h0, bus.note}, 32'h07);
        nxt();

        // ---------------- pause mid-note ----------------
        go_idle();
        bus.song_start = 1;
        nxt();
        bus.song_start = 0;
        for (int t = 0; t < 18; t++) begin
            bus.pause = (t >= 3 && t <= 12);
            @(negedge clock);
            if (t >= 3 && t <= 12) check($sformatf("pause_silent%0d", t), {24'h0, bus.note}, 32'h00);
            if (t == 2 || t == 13 || t == 15) check($sformatf("pause_audible%0d", t), {24'h0, bus.note}, 32'h05);
            if (t == 15) check("pause_addr_hold", {24'h0, bus.rom_addr}, 32'h00);
            if (t == 16) check("pause_addr_adv", {24'h0, bus.rom_addr}, 32'h01);
            nxt();
        end
        bus.pause = 0;

        // ---------------- randomized songs vs reference model ----------------
        for (int run = 0; run < 8; run++) begin
            go_idle();
            len     = $urandom_range(1, 5);
            loop_en = 1'($urandom_range(0, 1));
            for (int i = 0; i < 256; i++) rom[i] = 8'h11;
            for (int i = 0; i < len; i++) rom[i] = 8'($urandom_range(0, 254));
            rom[len] = 8'hFF;
            for (int i = 0; i < C; i++) pause_arr[i] = ($urandom_range(0, 4) == 0);
            build_model(len, loop_en);
            bus.song_loop = loop_en; bus.song_start = 1;
            nxt();
            bus.song_start = 0;
            for (int t = 0; t < C; t++) begin
                bus.pause = pause_arr[t];
                @(negedge clock);
                check($sformatf("rand%0d_t%0d", run, t), {22'h0, bus.note, bus.busy, bus.song_done},
                      {22'h0, exp_note[t], exp_busy[t], exp_done[t]});
                nxt();
            end
        end

        // ---------------- asynchronous reset mid-PLAY ----------------
        go_idle();
        load_basic();
        bus.song_start = 1;
        nxt();
        bus.song_start = 0;
        repeat (3) nxt();
        @(negedge clock);
        check("prereset_playing", {24'h0, bus.note}, 32'h05);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check("async_reset", outs(), 32'h0);
        #1 reset_n = 1'b1;
        nxt();

        // ---------------- address wrap, no END_CODE ----------------
        for (int i = 0; i < 256; i++) rom[i] = 8'h33;
        clear_inputs();
        bus.song_start = 1;
        nxt();
        bus.song_start = 0;
        found = 0;
        for (int t = 0; t < 2000 && !found; t++) begin
            @(negedge clock);
            if (bus.rom_addr == 8'hFF) found = 1;
            nxt();
        end
        check("wrap_reach_ff", {31'h0, found}, 32'h1);
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clock);
            if (bus.rom_addr != 8'hFF) found = 1;
            else nxt();
        end
        check("wrap_to_00", {23'h0, found, bus.rom_addr}, {23'h0, 1'b1, 8'h00});
        check("wrap_busy", {31'h0, bus.busy}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
